// File: rtl/inst_encoder.sv
// RV32I field-to-word encoder feeding instruction memory through a small FIFO.
// Optional immediate range checking is compiled in with `define INST_ENC_RANGE_CHECK_EN.
module inst_encoder #(
  parameter int                 DEPTH     = 4,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [6:0]                in_opcode,
  input  logic [2:0]                in_func3,
  input  logic                      in_func7,
  input  logic [4:0]                in_rs1,
  input  logic [4:0]                in_rs2,
  input  logic [4:0]                in_rd,
  input  logic [31:0]               in_imm,
  output logic                      im_we,
  input  logic                      im_ready,
  output logic [ADDR_W-1:0]         im_addr,
  output logic [31:0]               im_wdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err
);
  localparam int              PW       = $clog2(DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  logic [31:0]       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_illegal, push_bad, is_shift;
  logic        push, pop, empty, full;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign in_ready = !full;
  assign push     = in_valid && !full && !flush;
  assign pop      = !empty && im_ready && !flush;
  assign is_shift = (in_opcode == 7'b0010011) && (in_func3[1:0] == 2'b01);

  always_comb begin
    enc_word    = 32'h0000_0013;
    enc_illegal = 1'b0;
    case (in_opcode)
      7'b0110011:
        enc_word = {1'b0, in_func7, 5'b0, in_rs2, in_rs1, in_func3, in_rd, in_opcode};
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011:
        if (is_shift)
          enc_word = {1'b0, in_func7, 5'b0, in_imm[4:0], in_rs1, in_func3, in_rd, in_opcode};
        else
          enc_word = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
      7'b0100011:
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode};
      7'b1100011:
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                    in_imm[4:1], in_imm[11], in_opcode};
      7'b0110111, 7'b0010111:
        enc_word = {in_imm[31:12], in_rd, in_opcode};
      7'b1101111:
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default:
        enc_illegal = 1'b1;
    endcase
  end

`ifdef INST_ENC_RANGE_CHECK_EN
  logic enc_range;

  // Sign-fit tests: all bits above the field's sign bit must equal it.
  always_comb begin
    enc_range = 1'b0;
    case (in_opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011:
        if (is_shift)
          enc_range = |in_imm[31:5];
        else
          enc_range = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      7'b0100011:
        enc_range = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      7'b1100011:
        enc_range = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      7'b0110111, 7'b0010111:
        enc_range = |in_imm[11:0];
      7'b1101111:
        enc_range = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      default:
        enc_range = 1'b0;
    endcase
  end

  assign push_bad = enc_illegal || enc_range;
`else
  assign push_bad = enc_illegal;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    err_d    = err_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE_ADDR;
      err_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (push_bad) err_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        addr_d   = addr_q + ADDR_W'(4);
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

  assign im_we    = !empty;
  assign im_addr  = addr_q;
  assign im_wdata = empty ? 32'h0 : mem_q[rd_ptr_q];
  assign count    = count_q;
  assign err      = err_q;

endmodule
